// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and defaults for the external bus arbiter
package bus_arb_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_COORD_WIDTH    = 32;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_HIGH_WATERMARK = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

  // One buffered output word with its coordinate tags, at default widths.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]  data;
    logic [DEF_COORD_WIDTH-1:0] x;
    logic [DEF_COORD_WIDTH-1:0] y;
    logic [DEF_COORD_WIDTH-1:0] ch;
  } out_entry_t;

  // Flattened width of a FIFO entry {data, x, y, ch}.
  function automatic int entry_width(input int dw, input int cw);
    return dw + 3 * cw;
  endfunction

endpackage

// File: rtl/ext_bus_arbiter_if.sv
// rtl/ext_bus_arbiter_if.sv - load/writeback handshake bundle between controller, datapath and bus
interface ext_bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
);

  logic                   ld_req;
  logic                   ld_grant;
  logic                   con_valid;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COORD_WIDTH-1:0] out_x;
  logic [COORD_WIDTH-1:0] out_y;
  logic [COORD_WIDTH-1:0] out_ch;
  logic                   out_stall;
  logic                   bus_rd_ready;
  logic                   bus_rd_valid;
  logic                   bus_wr_valid;
  logic                   bus_wr_ready;
  logic [DATA_WIDTH-1:0]  bus_wr_data;
  logic [COORD_WIDTH-1:0] bus_wr_x;
  logic [COORD_WIDTH-1:0] bus_wr_y;
  logic [COORD_WIDTH-1:0] bus_wr_ch;
  logic                   busy;
  logic                   overflow_err;

  // Arbiter side.
  modport slave (
    input  ld_req, out_valid, out_data, out_x, out_y, out_ch,
           bus_rd_valid, bus_wr_ready,
    output ld_grant, con_valid, out_stall, bus_rd_ready, bus_wr_valid,
           bus_wr_data, bus_wr_x, bus_wr_y, bus_wr_ch, busy, overflow_err
  );

  // Controller / datapath / bus side.
  modport master (
    output ld_req, out_valid, out_data, out_x, out_y, out_ch,
           bus_rd_valid, bus_wr_ready,
    input  ld_grant, con_valid, out_stall, bus_rd_ready, bus_wr_valid,
           bus_wr_data, bus_wr_x, bus_wr_y, bus_wr_ch, busy, overflow_err
  );

endinterface

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - output word FIFO with occupancy count and look-ahead count
module out_fifo
  import bus_arb_pkg::*;
#(
  parameter int WIDTH = entry_width(DEF_DATA_WIDTH, DEF_COORD_WIDTH),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count_next,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Head is always visible; the consumer qualifies it with its own valid.
  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Occupancy after this cycle's push/pop; simultaneous push+pop cancels.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// rtl/ext_bus_arbiter.sv - shares the external bus between load bursts and buffered output writeback
module ext_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int COORD_WIDTH    = DEF_COORD_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int HIGH_WATERMARK = DEF_HIGH_WATERMARK
) (
  input  logic               clk,
  input  logic               arst_n_in,
  ext_bus_arbiter_if.slave   bus
);

  localparam int EW    = entry_width(DATA_WIDTH, COORD_WIDTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HWM_C = CNT_W'(HIGH_WATERMARK);

  arb_state_t       state;
  logic             ld_grant_q;
  logic             wr_mode_q;
  logic             overflow_q;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    head_entry;

  assign in_entry = {bus.out_data, bus.out_x, bus.out_y, bus.out_ch};

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop  = wr_mode_q && !empty && bus.bus_wr_ready;
  assign push = bus.out_valid && (!full || pop);

  out_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .push       (push),
    .pop        (pop),
    .wdata      (in_entry),
    .rdata      (head_entry),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // Arbitration FSM; grant/write-mode flags are registered alongside the state.
  // Decisions use the post-push/pop occupancy so a push in IDLE shows valid next cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= IDLE;
      ld_grant_q <= 1'b0;
      wr_mode_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count_next >= HWM_C) begin
            state     <= WRITE;
            wr_mode_q <= 1'b1;
          end else if (bus.ld_req) begin
            state      <= LOAD;
            ld_grant_q <= 1'b1;
          end else if (count_next != '0) begin
            state     <= WRITE;
            wr_mode_q <= 1'b1;
          end
        end
        LOAD: begin
          if (!bus.ld_req) begin
            state      <= IDLE;
            ld_grant_q <= 1'b0;
          end
        end
        WRITE: begin
          if (pop && ((count_next == '0) ||
                      (bus.ld_req && (count_next < HWM_C)))) begin
            state     <= IDLE;
            wr_mode_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          ld_grant_q <= 1'b0;
          wr_mode_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a word lost to a full FIFO with no concurrent pop.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      overflow_q <= 1'b0;
    end else if (bus.out_valid && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.ld_grant     = ld_grant_q;
  assign bus.bus_rd_ready = ld_grant_q && bus.ld_req;
  assign bus.con_valid    = ld_grant_q && bus.bus_rd_valid;
  assign bus.bus_wr_valid = wr_mode_q && !empty;
  assign bus.bus_wr_data  = head_entry[EW-1 -: DATA_WIDTH];
  assign bus.bus_wr_x     = head_entry[3*COORD_WIDTH-1 -: COORD_WIDTH];
  assign bus.bus_wr_y     = head_entry[2*COORD_WIDTH-1 -: COORD_WIDTH];
  assign bus.bus_wr_ch    = head_entry[COORD_WIDTH-1:0];
  assign bus.out_stall    = full;
  assign bus.busy         = (state != IDLE) || !empty;
  assign bus.overflow_err = overflow_q;

endmodule
